mem_port_sched: RTL



---
 rtl/mem_sched_pkg.sv | 17 +
 rtl/mem_port_sched_byte_assembler.sv | 34 +++
 rtl/mem_port_sched.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the byte-serial memory port scheduler.
package mem_sched_pkg;

  typedef enum logic [2:0] {IDLE, RD, RDTAIL, WR, GAP} schedStateT;
  typedef enum logic {FETCH, DATA} grantT;

  localparam logic [2:0] LEN_B  = 3'd1;
  localparam logic [2:0] LEN_H  = 3'd2;
  localparam logic [2:0] LEN_W  = 3'd4;
  localparam logic [1:0] IO_SEL = 2'b11;

  // Any length other than byte or half collapses to a full word.
  function automatic logic [2:0] lenDecode(input logic [2:0] len);
    return (len == LEN_B || len == LEN_H) ? len : LEN_W;
  endfunction

endpackage

// File: rtl/mem_port_sched_byte_assembler.sv
// Little-endian word assembler: clears on a new transfer, inserts one byte per lane.
module byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        insert,
  input  logic [1:0]  lane,
  input  logic [7:0]  insByte,
  output logic [31:0] word
);

  logic [31:0] acc;

  // NOTE: reset is sampled on the clock edge, and all state updates use <= so
  // every register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (insert) begin
      acc[{lane, 3'b000} +: 8] <= insByte;
    end
  end

  // The word seen by the ports already includes a byte arriving this cycle,
  // so the final byte is visible in the same cycle as the done pulse.
  // NOTE: word gets a full default before the conditional write, so no latch.
  always_comb begin
    word = acc;
    if (insert) word[{lane, 3'b000} +: 8] = insByte;
  end

endmodule

// File: rtl/mem_port_sched.sv
// Shares the 8-bit RAM/IO bus between instruction fetch and data port, byte by byte.
// Build option MEM_PORT_SCHED_IOGAP_EN inserts one idle GAP cycle after I/O writes.
module mem_port_sched #(
  parameter int ADDR_W = 32
`ifdef MEM_PORT_SCHED_IOGAP_EN
  , parameter logic [1:0] IO_SEL = mem_sched_pkg::IO_SEL
`endif
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  input  logic              if_abort_in,
  output logic              if_done_out,
  output logic [31:0]       if_data_out,
  input  logic              d_req_in,
  input  logic              d_we_in,
  input  logic [ADDR_W-1:0] d_addr_in,
  input  logic [31:0]       d_wdata_in,
  input  logic [2:0]        d_len_in,
  output logic              d_done_out,
  output logic [31:0]       d_rdata_out,
  output logic              busy_out,
  input  logic [7:0]        ram_din_in,
  output logic [7:0]        ram_dout_out,
  output logic [ADDR_W-1:0] ram_a_out,
  output logic              ram_wr_out
);
  import mem_sched_pkg::*;

  schedStateT        state, nextState;
  grantT             owner;
  logic [ADDR_W-1:0] baseAddr;
  logic [31:0]       wdata;
  logic [2:0]        len;
  logic [1:0]        cnt;
  logic              resume;

  logic        grantFetch, grantData;
  logic [1:0]  lastIdx;
  logic        advance, abortHit, reissue, capture;
  logic [1:0]  capLane;
  logic [31:0] asmWord;
  logic [ADDR_W-1:0] byteAddr;

  assign lastIdx  = 2'(len - 3'd1);
  // A resume cycle re-drives the previous read address because its data was lost during the stall.
  assign advance  = rdy_in && !resume;
  assign abortHit = (owner == FETCH) && if_abort_in && (state == RD || state == RDTAIL);
  assign reissue  = resume && (state == RD);
  assign byteAddr = baseAddr + ADDR_W'(reissue ? cnt - 2'd1 : cnt);

  // Data first, except that a waiting fetch gets the turn after a data grant.
  always_comb begin
    grantFetch = 1'b0;
    grantData  = 1'b0;
    if (state == IDLE && rdy_in) begin
      if (if_req_in && !if_abort_in && (owner == DATA || !d_req_in)) grantFetch = 1'b1;
      else if (d_req_in) grantData = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:   if (grantFetch || grantData) nextState = (grantData && d_we_in) ? WR : RD;
      RD: begin
        if (rdy_in && abortHit)                nextState = IDLE;
        else if (advance && cnt == lastIdx)    nextState = RDTAIL;
      end
      RDTAIL: if (rdy_in && (abortHit || !resume)) nextState = IDLE;
      WR: begin
        if (rdy_in && cnt == lastIdx) begin
`ifdef MEM_PORT_SCHED_IOGAP_EN
          nextState = (baseAddr[17:16] == IO_SEL) ? GAP : IDLE;
`else
          nextState = IDLE;
`endif
        end
      end
      GAP:     if (rdy_in) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      owner    <= DATA;
      baseAddr <= '0;
      wdata    <= '0;
      len      <= LEN_W;
      cnt      <= '0;
      resume   <= 1'b0;
    end else begin
      if (grantFetch) begin
        owner    <= FETCH;
        baseAddr <= if_addr_in;
        len      <= LEN_W;
        cnt      <= '0;
      end else if (grantData) begin
        owner    <= DATA;
        baseAddr <= d_addr_in;
        wdata    <= d_wdata_in;
        len      <= lenDecode(d_len_in);
        cnt      <= '0;
      end else if (advance && (state == RD || state == WR) && cnt != lastIdx) begin
        cnt <= cnt + 2'd1;
      end
      // Only a read with a byte in flight loses data while frozen.
      if (!rdy_in) resume <= (state == RD && cnt != 2'd0) || state == RDTAIL;
      else         resume <= 1'b0;
    end
  end

  assign capture = advance && !abortHit && ((state == RD && cnt != 2'd0) || state == RDTAIL);
  assign capLane = (state == RDTAIL) ? cnt : cnt - 2'd1;

  byte_assembler u_asm (
    .clk     (clk_in),
    .rst     (rst_in),
    .clear   (grantFetch || grantData),
    .insert  (capture),
    .lane    (capLane),
    .insByte (ram_din_in),
    .word    (asmWord)
  );

  assign if_data_out = (owner == FETCH) ? asmWord : '0;
  assign d_rdata_out = (owner == DATA)  ? asmWord : '0;

  // Done pulses are decoded from the state register and suppressed while frozen.
  always_comb begin
    ram_a_out    = '0;
    ram_dout_out = '0;
    ram_wr_out   = 1'b0;
    if_done_out  = 1'b0;
    d_done_out   = 1'b0;
    busy_out     = (state != IDLE);
    unique case (state)
      RD:     ram_a_out = byteAddr;
      RDTAIL: begin
        ram_a_out = byteAddr;
        if (advance) begin
          if (owner == FETCH) if_done_out = !if_abort_in;
          else                d_done_out  = 1'b1;
        end
      end
      WR: begin
        ram_a_out    = byteAddr;
        ram_dout_out = wdata[{cnt, 3'b000} +: 8];
        ram_wr_out   = rdy_in;
        d_done_out   = rdy_in && (cnt == lastIdx);
      end
      default: ;
    endcase
  end

endmodule
